// File: rtl/mux_pkg.sv
// Shared select encodings for the 4-to-1 selector family.
// Wider muxes and benches reuse these, so the encoding is defined in one place.
package mux_pkg;

    localparam logic [1:0] SEL_A = 2'b00;
    localparam logic [1:0] SEL_B = 2'b01;
    localparam logic [1:0] SEL_C = 2'b10;
    localparam logic [1:0] SEL_D = 2'b11;

    // s1 is the select MSB, s2 the LSB
    function automatic logic [1:0] sel_of(input logic s1, input logic s2);
        return {s1, s2};
    endfunction

endpackage

// File: rtl/mux_4_to_1_comb.sv
// Combinational 4-to-1 selector core.
// Ports:
//   a, b, c, d : WIDTH-bit data inputs
//   sel        : 2-bit select (SEL_A..SEL_D)
//   out        : selected data, zero latency
module mux_4_to_1_comb
    import mux_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] out
);

    always_comb begin
        out = 'x;
        case (sel)
            SEL_A:   out = a;
            SEL_B:   out = b;
            SEL_C:   out = c;
            SEL_D:   out = d;
            // only reachable with X/Z on the select; propagate X as a don't-care
            default: out = 'x;
        endcase
    end

endmodule

// File: rtl/mux_4_to_1.sv
// 4-to-1 selector with a combinational output and a registered copy.
// Ports:
//   a, b, c, d : WIDTH-bit data inputs (sel 0..3)
//   s1, s2     : select MSB / LSB
//   out        : combinational selected data (independent of clk/rst)
//   out_q      : out registered on rising clk, cleared by synchronous rst
//   clk        : rising-edge clock
//   rst        : synchronous active-high reset
// Data/select ports come first so positional instantiation of the first
// seven ports stays valid.
module mux_4_to_1
    import mux_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic             s1,
    input  logic             s2,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    input  logic             clk,
    input  logic             rst
);

    logic [1:0] sel;

    assign sel = sel_of(s1, s2);

    mux_4_to_1_comb #(
        .WIDTH (WIDTH)
    ) u_comb (
        .a   (a),
        .b   (b),
        .c   (c),
        .d   (d),
        .sel (sel),
        .out (out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
        end else begin
            out_q <= out;
        end
    end

endmodule

// File: tb/tb_mux_4_to_1.sv
module tb_mux_4_to_1;
    import mux_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a, b, c, d, out, out_q;
    logic       s1, s2;

    logic       a1, b1, c1, d1, x1, xq1, t1, t2;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    mux_4_to_1 #(.WIDTH(8)) u_dut (
        .a(a), .b(b), .c(c), .d(d), .s1(s1), .s2(s2),
        .out(out), .out_q(out_q), .clk(clk), .rst(rst)
    );

    mux_4_to_1 #(.WIDTH(1)) u_dut1 (
        .a(a1), .b(b1), .c(c1), .d(d1), .s1(t1), .s2(t2),
        .out(x1), .out_q(xq1), .clk(clk), .rst(rst)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model(input logic [1:0] sel, input logic [7:0] va,
                                         input logic [7:0] vb, input logic [7:0] vc,
                                         input logic [7:0] vd);
        logic [7:0] v[4];
        v[0] = va; v[1] = vb; v[2] = vc; v[3] = vd;
        return v[sel];
    endfunction

    // apply one cycle of stimulus, check the comb path, queue the expected out_q
    task automatic drive(input string tag, input logic r, input logic [1:0] sel,
                         input logic [7:0] va, input logic [7:0] vb,
                         input logic [7:0] vc, input logic [7:0] vd);
        logic [7:0] m;
        rst = r; {s1, s2} = sel;
        a = va; b = vb; c = vc; d = vd;
        m = model(sel, va, vb, vc, vd);
        #1;
        chk({tag, "_comb"}, out, m);
        exp_q.push_back(r ? 8'h00 : m);
    endtask

    task automatic edge_check(input string tag);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 8'h01, 8'h00);
        end else begin
            chk({tag, "_q"}, out_q, exp_q.pop_front());
        end
    endtask

    initial begin
        logic [7:0] ra, rb, rc, rd;
        logic [1:0] seq[4];
        seq[0] = SEL_A; seq[1] = SEL_D; seq[2] = SEL_B; seq[3] = SEL_C;

        rst = 1'b1;
        a = 8'h11; b = 8'h22; c = 8'h33; d = 8'h44; s1 = 1'b0; s2 = 1'b0;
        a1 = 1'b0; b1 = 1'b1; c1 = 1'b0; d1 = 1'b1; t1 = 1'b0; t2 = 1'b0;

        // WIDTH=1 select sweep, done while reset is held: out must still be valid
        for (int i = 0; i < 4; i++) begin
            {t1, t2} = 2'(i);
            #1;
            chk($sformatf("w1_sel%0d", i), {7'b0, x1}, {7'b0, i[0]});
            #9;
        end
        chk("w1_q_in_reset", {7'b0, xq1}, 8'h00);

        @(posedge clk);
        #1;

        // WIDTH=8, sel=C, comb follows data with no clock
        drive("w8_selc", 1'b1, SEL_C, 8'h11, 8'h22, 8'h33, 8'h44);
        c = 8'hA5;
        #1;
        chk("w8_c_change", out, 8'hA5);
        edge_check("rst1");
        drive("rst2", 1'b1, SEL_C, 8'h11, 8'h22, 8'hA5, 8'h44);
        edge_check("rst2");

        // release with sel=D, d=1
        drive("rel", 1'b0, SEL_D, 8'h11, 8'h22, 8'hA5, 8'h01);
        edge_check("rel");

        // mid-stream reset for one edge, comb keeps tracking
        drive("mid_rst", 1'b1, SEL_D, 8'h11, 8'h22, 8'hA5, 8'h01);
        edge_check("mid_rst");
        chk("mid_rst_out", out, 8'h01);
        drive("post_rst", 1'b0, SEL_D, 8'h11, 8'h22, 8'hA5, 8'h01);
        edge_check("post_rst");

        // rst pulse between edges must not touch out_q
        rst = 1'b1;
        #2;
        chk("rst_between_edges", out_q, 8'h01);
        rst = 1'b0;
        #1;

        // select toggled 0,3,1,2 with data and select changing together
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) begin
                ra = 8'($urandom); rb = 8'($urandom); rc = 8'($urandom); rd = 8'($urandom);
                drive($sformatf("tog%0d_%0d", r, i), 1'b0, seq[i], ra, rb, rc, rd);
                edge_check($sformatf("tog%0d_%0d", r, i));
            end
        end

        // X on s1 is a don't-care; once cleared, out is valid with no residue
        drive("pre_x", 1'b0, SEL_B, 8'h10, 8'h20, 8'h30, 8'h40);
        s1 = 1'bx;
        #1;
        s1 = 1'b0;
        #1;
        chk("x_recover", out, 8'h20);
        edge_check("x_recover");

        // random stream with occasional resets
        for (int i = 0; i < 24; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 8'($urandom); rd = 8'($urandom);
            drive($sformatf("rnd%0d", i), ($urandom_range(0, 5) == 0), 2'($urandom_range(0, 3)),
                  ra, rb, rc, rd);
            edge_check($sformatf("rnd%0d", i));
        end

        chk("sb_drain", 8'(exp_q.size()), 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
